// File: rtl/rng_stream_scheduler_if.sv
// rng_stream_scheduler_if: command/stream bus between the RNG scheduler and its LFSR/UART neighbours
interface rng_stream_scheduler_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [15:0] lfsr_word;
  logic rx_valid;
  logic [7:0] rx_byte;
  logic tx_free;
  logic tx_transmit;
  logic [7:0] tx_byte;
  logic reseed;
  logic streaming;
  logic [COUNT_WIDTH-1:0] bytes_sent;
  modport master (
    output lfsr_word, rx_valid, rx_byte, tx_free,
    input tx_transmit, tx_byte, reseed, streaming, bytes_sent
  );
  modport slave (
    input lfsr_word, rx_valid, rx_byte, tx_free,
    output tx_transmit, tx_byte, reseed, streaming, bytes_sent
  );
endinterface

// File: rtl/rng_stream_scheduler.sv
// rng_stream_scheduler: paces LFSR bytes onto the UART under rx commands; RNG_SCHED_FOLD_EN folds the high byte into the sample
module rng_stream_scheduler #(
  parameter int SPACING = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  rng_stream_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SPACE, SEND, GETLEN} state_t;
  localparam logic [7:0] LAST = 8'(SPACING - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, burst_q, burst_d, sample, byte_q;
  logic burst_mode_q, burst_mode_d, go, tx_q, reseed_q, streaming_q;
  logic cmd_r, cmd_s, cmd_p, cmd_b;
  logic [COUNT_WIDTH-1:0] sent_q;
`ifdef RNG_SCHED_FOLD_EN
  assign sample = bus.lfsr_word[15:8] ^ bus.lfsr_word[7:0];
`else
  logic unused_hi;
  assign unused_hi = ^bus.lfsr_word[15:8];
  assign sample = bus.lfsr_word[7:0];
`endif
  assign cmd_r = bus.rx_valid && bus.rx_byte == 8'h72;
  assign cmd_s = bus.rx_valid && state_q != GETLEN && bus.rx_byte == 8'h73;
  assign cmd_p = bus.rx_valid && state_q != GETLEN && bus.rx_byte == 8'h70;
  assign cmd_b = bus.rx_valid && state_q != GETLEN && bus.rx_byte == 8'h62;
  // Commands take priority over spacing expiry, so a decoded command suppresses that cycle's strobe.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    burst_d = burst_q;
    burst_mode_d = burst_mode_q;
    go = 1'b0;
    if (cmd_r) begin
      state_d = IDLE;
      burst_d = '0;
    end else if (state_q == GETLEN) begin
      if (bus.rx_valid) begin
        state_d = bus.rx_byte == 8'd0 ? IDLE : SPACE;
        burst_d = bus.rx_byte;
        burst_mode_d = bus.rx_byte != 8'd0 ? 1'b1 : burst_mode_q;
        cnt_d = '0;
      end
    end else if (cmd_s) begin
      state_d = SPACE;
      burst_mode_d = 1'b0;
      cnt_d = '0;
    end else if (cmd_p) begin
      state_d = IDLE;
    end else if (cmd_b) begin
      state_d = GETLEN;
    end else if (state_q == SPACE) begin
      go = cnt_q == LAST && bus.tx_free;
      state_d = go ? SEND : SPACE;
      cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 8'd1;
    end else if (state_q == SEND) begin
      cnt_d = '0;
      burst_d = burst_mode_q ? burst_q - 8'd1 : burst_q;
      state_d = burst_mode_q && burst_q == 8'd1 ? IDLE : SPACE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      burst_q <= '0;
      burst_mode_q <= 1'b0;
      sent_q <= '0;
      tx_q <= 1'b0;
      byte_q <= '0;
      reseed_q <= 1'b0;
      streaming_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      burst_q <= burst_d;
      burst_mode_q <= burst_mode_d;
      sent_q <= cmd_r ? '0 : sent_q + COUNT_WIDTH'(state_q == SEND);
      tx_q <= go;
      byte_q <= go ? sample : byte_q;
      reseed_q <= cmd_r;
      streaming_q <= state_d == SPACE || state_d == SEND;
    end
  end
  assign bus.tx_transmit = tx_q;
  assign bus.tx_byte = byte_q;
  assign bus.reseed = reseed_q;
  assign bus.streaming = streaming_q;
  assign bus.bytes_sent = sent_q;
endmodule
